exu_gpr_wb_sched: RTL and testbench

Writeback scheduler and scoreboard for the EXU general-purpose register file. It shares the single GPR write port among several writeback sources (ALU, LSU, MDU) using round-robin arbitration. It tracks one pending-write busy bit per architectural register and stalls issue on RAW and WAW hazards. It sits between the issue stage, the functional-unit writeback paths and the GPR write port.

---
 rtl/exu_gpr_wb_sched_pkg.sv | 25 ++
 rtl/exu_gpr_wb_sched_if.sv | 16 +
 rtl/exu_gpr_wb_sched_rr_arb.sv | 47 ++++
 rtl/exu_gpr_wb_sched.sv | 117 +++++++++++
 tb/tb_exu_gpr_wb_sched.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exu_gpr_wb_sched_pkg.sv
// Shared types and constants for the EXU GPR writeback scheduler slice.
// Holds writeback source ids, the request record and the round-robin wrap helper.
package exu_pkg;

    localparam int NUM_WB_SRC = 3;
    localparam int XLEN_DEF   = 32;
    localparam int GPR_AW_DEF = 5;

    typedef enum logic [1:0] {
        WB_SRC_ALU = 2'd0,
        WB_SRC_LSU = 2'd1,
        WB_SRC_MDU = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic [GPR_AW_DEF-1:0] addr;
        logic [XLEN_DEF-1:0]   data;
    } wb_req_t;

    // Modulo-n wrap for an index known to be below 2*n.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/exu_gpr_wb_sched_if.sv
// GPR write port bundle: the scheduler drives it (mst), the register file consumes it (slv).
interface exu_gpr_w_if_t
    import exu_pkg::*;
#(
    parameter int AW   = GPR_AW_DEF,
    parameter int XLEN = XLEN_DEF
);

    logic            wen;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;

    modport mst (output wen, output addr, output data);
    modport slv (input  wen, input  addr, input  data);

endinterface

// File: rtl/exu_gpr_wb_sched_rr_arb.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past the winner.
// Grant is combinational; the pointer only advances when a grant is taken.
module exu_rr_arb
    import exu_pkg::*;
#(
    parameter int N = NUM_WB_SRC
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;
    int            idx;

    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves one unassigned (no latch).
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = rr_wrap(int'(ptr_q) + k, N);
            if (req[idx] && !found) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                ptr_d      = PW'(rr_wrap(idx + 1, N));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/exu_gpr_wb_sched.sv
// GPR writeback scheduler: arbitrates writeback sources onto the single write port
// and keeps a per-register pending-write scoreboard that stalls issue on RAW/WAW.
module exu_gpr_wb_sched
    import exu_pkg::*;
#(
    parameter int NUM_SRC = NUM_WB_SRC,
    parameter int XLEN    = XLEN_DEF,
    parameter int AW      = GPR_AW_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    iss_vld,
    input  logic                    iss_rs1_vld,
    input  logic [AW-1:0]           iss_rs1,
    input  logic                    iss_rs2_vld,
    input  logic [AW-1:0]           iss_rs2,
    input  logic                    iss_rd_vld,
    input  logic [AW-1:0]           iss_rd,
    output logic                    iss_stall,
    input  logic [NUM_SRC-1:0]      wb_vld,
    input  logic [NUM_SRC*AW-1:0]   wb_addr,
    input  logic [NUM_SRC*XLEN-1:0] wb_data,
    output logic [NUM_SRC-1:0]      wb_rdy,
    exu_gpr_w_if_t.mst              gpr_w_mst,
    output logic                    idle,
    output logic                    wb_err
);

    localparam int NREG = 1 << AW;

    logic [NREG-1:0] busy_q, busy_d;
    logic            wen_q, wen_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            err_q, err_d;

    logic [NUM_SRC-1:0] grant;
    logic               any_req;
    logic [AW-1:0]      sel_addr;
    logic [XLEN-1:0]    sel_data;
    logic               iss_set;
    logic               tgt_busy;

    assign any_req = |wb_vld;

    exu_rr_arb #(.N(NUM_SRC)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (wb_vld),
        .advance (any_req),
        .grant   (grant)
    );

    assign wb_rdy = grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                sel_addr = wb_addr[i*AW +: AW];
                sel_data = wb_data[i*XLEN +: XLEN];
            end
        end
    end

    // Hazards see registered busy only; a write landing this cycle still stalls.
    assign iss_stall = iss_vld & ((iss_rs1_vld & busy_q[iss_rs1]) |
                                  (iss_rs2_vld & busy_q[iss_rs2]) |
                                  (iss_rd_vld  & busy_q[iss_rd]));

    assign iss_set = iss_vld & ~iss_stall & iss_rd_vld & (iss_rd != '0);

    // A write already in the stage retires its register at this edge, so it no longer counts as pending.
    assign tgt_busy = busy_q[sel_addr] & ~(wen_q & (addr_q == sel_addr));

    always_comb begin
        busy_d = busy_q;
        if (wen_q) begin
            busy_d[addr_q] = 1'b0;
        end
        if (iss_set) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        wen_d  = any_req & (sel_addr != '0);
        addr_d = any_req ? sel_addr : addr_q;
        data_d = any_req ? sel_data : data_q;
        err_d  = err_q | (any_req & (sel_addr != '0) & ~tgt_busy);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: busy is a flop vector, not a RAM, so clearing it on reset is cheap and required.
            busy_q <= '0;
            wen_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            wen_q  <= wen_d;
            addr_q <= addr_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    assign gpr_w_mst.wen  = wen_q;
    assign gpr_w_mst.addr = addr_q;
    assign gpr_w_mst.data = data_q;

    assign idle   = ~|busy_q & ~wen_q;
    assign wb_err = err_q;

endmodule

// File: tb/tb_exu_gpr_wb_sched.sv
// Scoreboard bench for exu_gpr_wb_sched: a register-level model predicts stalls, grants
// and writes; a separate monitor pops expected writes whenever the write port is sampled.
module tb_exu_gpr_wb_sched;
    import exu_pkg::*;

    localparam int NS   = NUM_WB_SRC;
    localparam int AW   = GPR_AW_DEF;
    localparam int XLEN = XLEN_DEF;
    localparam int NREG = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                iss_vld, iss_rs1_vld, iss_rs2_vld, iss_rd_vld;
    logic [AW-1:0]       iss_rs1, iss_rs2, iss_rd;
    logic                iss_stall;
    logic [NS-1:0]       wb_vld;
    logic [NS*AW-1:0]    wb_addr;
    logic [NS*XLEN-1:0]  wb_data;
    logic [NS-1:0]       wb_rdy;
    logic                idle, wb_err;

    exu_gpr_w_if_t #(.AW(AW), .XLEN(XLEN)) gpr_if ();

    exu_gpr_wb_sched #(.NUM_SRC(NS), .XLEN(XLEN), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .iss_vld     (iss_vld),
        .iss_rs1_vld (iss_rs1_vld),
        .iss_rs1     (iss_rs1),
        .iss_rs2_vld (iss_rs2_vld),
        .iss_rs2     (iss_rs2),
        .iss_rd_vld  (iss_rd_vld),
        .iss_rd      (iss_rd),
        .iss_stall   (iss_stall),
        .wb_vld      (wb_vld),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_rdy      (wb_rdy),
        .gpr_w_mst   (gpr_if),
        .idle        (idle),
        .wb_err      (wb_err)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model state
    bit            mbusy [NREG];
    bit            pend_v;
    logic [AW-1:0] pend_a;
    bit            merr;
    int            pri;
    wb_req_t       uq [NS][$];
    bit            holding [NS];
    wb_req_t       expq [$];
    bit            auto_mode;
    bit            force_present;
    logic [NS-1:0] last_rdy;
    logic          last_stall;

    // Architectural register file seen through the write port
    logic [XLEN-1:0] gpr_tb [NREG];
    always @(posedge clk) if (gpr_if.wen === 1'b1) gpr_tb[gpr_if.addr] <= gpr_if.data;

    // Monitor: every cycle the write port is either retiring the oldest expected write or silent
    initial begin
        wb_req_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    check("wr_wen", {31'd0, gpr_if.wen}, 32'd1);
                    check("wr_addr", {27'd0, gpr_if.addr}, {27'd0, e.addr});
                    check("wr_data", gpr_if.data, e.data);
                end else begin
                    check("wr_quiet", {31'd0, gpr_if.wen}, 32'd0);
                end
            end
        end
    end

    function automatic bit model_idle();
        bit any = 1'b0;
        for (int r = 0; r < NREG; r++) any |= mbusy[r];
        return !any && !pend_v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) mbusy[r] = 1'b0;
        pend_v = 1'b0;
        merr   = 1'b0;
        pri    = 0;
        for (int i = 0; i < NS; i++) begin
            uq[i].delete();
            holding[i] = 1'b0;
        end
        expq.delete();
    endtask

    task automatic set_iss(input int v, input int r1v, input int r1, input int r2v,
                           input int r2, input int rdv, input int rd);
        iss_vld     = v[0];
        iss_rs1_vld = r1v[0];
        iss_rs1     = AW'(r1);
        iss_rs2_vld = r2v[0];
        iss_rs2     = AW'(r2);
        iss_rd_vld  = rdv[0];
        iss_rd      = AW'(rd);
    endtask

    task automatic rand_issue();
        set_iss($urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(15, 0),
                $urandom_range(1, 0), $urandom_range(15, 0),
                $urandom_range(1, 0), $urandom_range(15, 0));
    endtask

    task automatic push_wb(input int src, input int addr, input logic [XLEN-1:0] data);
        wb_req_t r;
        r.addr = AW'(addr);
        r.data = data;
        uq[src].push_back(r);
    endtask

    // One clock cycle: drive at negedge, compare combinational outputs, advance the model at posedge.
    task automatic step();
        int      g;
        bit      exp_stall;
        wb_req_t h;
        for (int i = 0; i < NS; i++) begin
            if (!holding[i] && uq[i].size() > 0 && (force_present || $urandom_range(1, 0) == 1))
                holding[i] = 1'b1;
            wb_vld[i] = holding[i];
            if (holding[i]) begin
                h = uq[i][0];
                wb_addr[i*AW +: AW]     = h.addr;
                wb_data[i*XLEN +: XLEN] = h.data;
            end else begin
                wb_addr[i*AW +: AW]     = AW'($urandom);
                wb_data[i*XLEN +: XLEN] = $urandom;
            end
        end
        #1;
        exp_stall = iss_vld && ((iss_rs1_vld && mbusy[iss_rs1]) ||
                                (iss_rs2_vld && mbusy[iss_rs2]) ||
                                (iss_rd_vld  && mbusy[iss_rd]));
        g = -1;
        for (int k = 0; k < NS; k++) begin
            int idx;
            idx = (pri + k) % NS;
            if (g < 0 && wb_vld[idx]) g = idx;
        end
        check("iss_stall", {31'd0, iss_stall}, {31'd0, exp_stall});
        check("wb_rdy", {29'd0, wb_rdy}, (g < 0) ? 32'd0 : (32'd1 << g));
        check("wb_err", {31'd0, wb_err}, {31'd0, merr});
        check("idle", {31'd0, idle}, {31'd0, model_idle()});
        last_stall = iss_stall;
        last_rdy   = wb_rdy;
        @(posedge clk);
        if (pend_v) begin
            mbusy[pend_a] = 1'b0;
            pend_v = 1'b0;
        end
        if (g >= 0) begin
            h = uq[g].pop_front();
            holding[g] = 1'b0;
            pri = (g + 1) % NS;
            if (h.addr != '0) begin
                if (!mbusy[h.addr]) merr = 1'b1;
                expq.push_back(h);
                pend_v = 1'b1;
                pend_a = h.addr;
            end
        end
        if (iss_vld && !exp_stall && iss_rd_vld && iss_rd != '0) begin
            mbusy[iss_rd] = 1'b1;
            if (auto_mode) push_wb($urandom_range(NS - 1, 0), int'(iss_rd), $urandom);
        end
        if (auto_mode && $urandom_range(15, 0) == 0) push_wb($urandom_range(NS - 1, 0), 0, $urandom);
        @(negedge clk);
    endtask

    task automatic drain();
        bit done = 1'b0;
        set_iss(0, 0, 0, 0, 0, 0, 0);
        auto_mode = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            step();
            done = model_idle();
            for (int i = 0; i < NS; i++) if (uq[i].size() > 0) done = 1'b0;
        end
        check("drain_done", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NS-1:0] r [4];
        int n;
        set_iss(0, 0, 0, 0, 0, 0, 0);
        wb_addr = '0;
        wb_data = '0;
        wb_vld  = 3'b110;
        auto_mode = 1'b0;
        force_present = 1'b0;
        model_reset();
        #1;
        check("rst_wen", {31'd0, gpr_if.wen}, 32'd0);
        check("rst_addr", {27'd0, gpr_if.addr}, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd1);
        check("rst_err", {31'd0, wb_err}, 32'd0);
        check("rst_rdy_lowest", {29'd0, wb_rdy}, 32'd2);
        wb_vld = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic with units returning results for every issued rd
        auto_mode = 1'b1;
        for (int c = 0; c < 400; c++) begin
            rand_issue();
            step();
        end
        drain();

        // Mid-traffic asynchronous reset with a busy register and a write in flight
        set_iss(1, 0, 0, 0, 0, 1, 5);
        step();
        set_iss(1, 0, 0, 0, 0, 1, 6);
        step();
        set_iss(0, 0, 0, 0, 0, 0, 0);
        force_present = 1'b1;
        push_wb(WB_SRC_ALU, 6, 32'h0000_1234);
        step();
        #2;
        rst_n  = 1'b0;
        wb_vld = '0;
        set_iss(1, 1, 5, 0, 0, 0, 0);
        #1;
        check("midrst_wen", {31'd0, gpr_if.wen}, 32'd0);
        check("midrst_err", {31'd0, wb_err}, 32'd0);
        check("midrst_idle", {31'd0, idle}, 32'd1);
        check("midrst_stall", {31'd0, iss_stall}, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_rs1_5", {31'd0, last_stall}, 32'd0);

        // Three sources at once from a reset pointer
        for (int d = 1; d <= 3; d++) begin
            set_iss(1, 0, 0, 0, 0, 1, d);
            step();
        end
        set_iss(0, 0, 0, 0, 0, 0, 0);
        push_wb(WB_SRC_ALU, 1, 32'hA1A1_0001);
        push_wb(WB_SRC_LSU, 2, 32'hB2B2_0002);
        push_wb(WB_SRC_MDU, 3, 32'hC3C3_0003);
        for (int k = 0; k < 3; k++) begin
            step();
            r[k] = last_rdy;
        end
        check("rr_grant0", {29'd0, r[0]}, 32'd1);
        check("rr_grant1", {29'd0, r[1]}, 32'd2);
        check("rr_grant2", {29'd0, r[2]}, 32'd4);
        repeat (2) step();
        check("rr_idle_after", {31'd0, idle}, 32'd1);
        check("rr_x3", gpr_tb[3], 32'hC3C3_0003);

        // RAW on x5 resolved by an LSU writeback
        set_iss(1, 0, 0, 0, 0, 1, 5);
        step();
        set_iss(1, 1, 5, 0, 0, 0, 0);
        push_wb(WB_SRC_LSU, 5, 32'hDEAD_BEEF);
        step();
        check("raw_stall", {31'd0, last_stall}, 32'd1);
        check("raw_wen", {31'd0, gpr_if.wen}, 32'd1);
        check("raw_waddr", {27'd0, gpr_if.addr}, 32'd5);
        step();
        check("raw_stall_wcycle", {31'd0, last_stall}, 32'd1);
        step();
        check("raw_release", {31'd0, last_stall}, 32'd0);
        check("raw_x5", gpr_tb[5], 32'hDEAD_BEEF);

        // Sources 0 and 2 continuously requesting
        for (int d = 10; d <= 13; d++) begin
            set_iss(1, 0, 0, 0, 0, 1, d);
            step();
        end
        set_iss(0, 0, 0, 0, 0, 0, 0);
        push_wb(WB_SRC_ALU, 10, 32'h0A0A_0010);
        push_wb(WB_SRC_ALU, 12, 32'h0A0A_0012);
        push_wb(WB_SRC_MDU, 11, 32'h0C0C_0011);
        push_wb(WB_SRC_MDU, 13, 32'h0C0C_0013);
        for (int k = 0; k < 4; k++) begin
            step();
            r[k] = last_rdy;
        end
        for (int k = 0; k < 4; k++)
            check("alt_no_lsu", {31'd0, r[k] == 3'b001 || r[k] == 3'b100}, 32'd1);
        for (int k = 1; k < 4; k++)
            check("alt_switch", {31'd0, r[k] != r[k-1]}, 32'd1);
        repeat (2) step();

        // rd=x0 and writeback to x0
        set_iss(1, 0, 0, 0, 0, 1, 0);
        step();
        check("x0_no_stall", {31'd0, last_stall}, 32'd0);
        check("x0_no_busy", {31'd0, idle}, 32'd1);
        set_iss(0, 0, 0, 0, 0, 0, 0);
        push_wb(WB_SRC_ALU, 0, 32'h0000_ABCD);
        step();
        check("x0_rdy", {29'd0, last_rdy}, 32'd1);
        check("x0_wen", {31'd0, gpr_if.wen}, 32'd0);
        check("x0_err", {31'd0, wb_err}, 32'd0);

        // WAW on x7: second issue waits for the first write to land
        set_iss(1, 0, 0, 0, 0, 1, 7);
        step();
        step();
        check("waw_stall", {31'd0, last_stall}, 32'd1);
        push_wb(WB_SRC_ALU, 7, 32'h0000_0077);
        n = 0;
        do begin
            step();
            n++;
        end while (last_stall && n < 10);
        check("waw_release_cycles", n, 32'd3);
        set_iss(0, 0, 0, 0, 0, 0, 0);
        push_wb(WB_SRC_ALU, 7, 32'h0000_0078);
        repeat (3) step();

        // MDU writeback to a register nobody is waiting on
        push_wb(WB_SRC_MDU, 9, 32'hCAFE_0009);
        step();
        step();
        check("spur_err", {31'd0, wb_err}, 32'd1);
        check("spur_x9", gpr_tb[9], 32'hCAFE_0009);

        auto_mode = 1'b1;
        force_present = 1'b0;
        for (int c = 0; c < 150; c++) begin
            rand_issue();
            step();
        end
        drain();
        check("err_sticky", {31'd0, wb_err}, 32'd1);

        #2;
        rst_n = 1'b0;
        #1;
        check("final_rst_err", {31'd0, wb_err}, 32'd0);
        check("final_rst_idle", {31'd0, idle}, 32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
